lenet_layer_sched: RTL

//  Top-level layer sequencer for the LeNet accelerator. Runs the layer engines (conv1, pool1, conv2, pool2,
//  fc1, fc2) one at a time through their en/finish handshakes, honouring a per-run skip mask.

---
 rtl/lenet_pkg.sv | 32 +++
 rtl/lenet_layer_sched_if.sv | 28 ++
 rtl/bram_port_mux.sv | 36 +++
 rtl/lenet_layer_sched.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet layer sequencer: layer indices, bus widths and
// the one-hot scheduler state encoding.
package lenet_pkg;

  localparam int LENET_N_LAYERS = 6;
  localparam int DATA_SIZE      = 8;
  localparam int LENET_ADDR_W   = 15;

  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_FC1   = 4;
  localparam int L_FC2   = 5;

  // Per-layer watchdog width; wide enough for the 2**20 default limit.
  localparam int WD_W = 21;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_SEEK = 6'b000010,
    S_RUN  = 6'b000100,
    S_GAP  = 6'b001000,
    S_DONE = 6'b010000,
    S_ERR  = 6'b100000
  } sched_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lenet_layer_sched_if.sv
// Engine-side bundle of the layer sequencer: en/finish handshakes, per-engine
// BRAM requests and the shared result BRAM port A.
interface lenet_layer_sched_if #(
  parameter int N_LAYERS = 6,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15
);
  logic [N_LAYERS-1:0]             layer_en;
  logic [N_LAYERS-1:0]             layer_finish;
  logic [N_LAYERS-1:0]             lyr_ena;
  logic [N_LAYERS-1:0]             lyr_wea;
  logic [N_LAYERS-1:0][ADDR_W-1:0] lyr_addra;
  logic [N_LAYERS-1:0][DATA_W-1:0] lyr_dina;
  logic                            bram_ena;
  logic                            bram_wea;
  logic [ADDR_W-1:0]               bram_addra;
  logic [DATA_W-1:0]               bram_dina;

  modport master (
    output layer_en, bram_ena, bram_wea, bram_addra, bram_dina,
    input  layer_finish, lyr_ena, lyr_wea, lyr_addra, lyr_dina
  );

  modport slave (
    input  layer_en, bram_ena, bram_wea, bram_addra, bram_dina,
    output layer_finish, lyr_ena, lyr_wea, lyr_addra, lyr_dina
  );
endinterface

// File: rtl/bram_port_mux.sv
// N-way selector from per-engine BRAM requests onto one BRAM port; force_idle
// parks the port with every field at zero.
module bram_port_mux
  import lenet_pkg::*;
#(
  parameter int  N      = 6,
  parameter int  DATA_W = 8,
  parameter int  ADDR_W = 15,
  localparam int SEL_W  = idx_width(N)
) (
  input  logic                     force_idle,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N-1:0]             in_ena,
  input  logic [N-1:0]             in_wea,
  input  logic [N-1:0][ADDR_W-1:0] in_addra,
  input  logic [N-1:0][DATA_W-1:0] in_dina,
  output logic                     out_ena,
  output logic                     out_wea,
  output logic [ADDR_W-1:0]        out_addra,
  output logic [DATA_W-1:0]        out_dina
);

  always_comb begin
    out_ena   = 1'b0;
    out_wea   = 1'b0;
    out_addra = '0;
    out_dina  = '0;
    if (!force_idle && (int'(sel) < N)) begin
      out_ena   = in_ena[sel];
      out_wea   = in_wea[sel];
      out_addra = in_addra[sel];
      out_dina  = in_dina[sel];
    end
  end

endmodule

// File: rtl/lenet_layer_sched.sv
// LeNet layer sequencer: runs each non-skipped layer engine in turn, hands it
// the result BRAM port while it runs, and traps engines that never finish.
module lenet_layer_sched
  import lenet_pkg::*;
#(
  parameter int  N_LAYERS   = LENET_N_LAYERS,
  parameter int  DATA_W     = DATA_SIZE,
  parameter int  ADDR_W     = LENET_ADDR_W,
  parameter int  GAP_CYCLES = 2,
  parameter int  TIMEOUT    = 2**20,
  localparam int IDX_W      = idx_width(N_LAYERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_LAYERS-1:0] skip_mask,
  lenet_layer_sched_if.master bus,
  output logic [IDX_W-1:0]    cur_layer,
  output logic                busy,
  output logic                done,
  output logic                error
);

  // idx needs one extra code so SEEK can see "past the last layer".
  localparam int SEEK_W = $clog2(N_LAYERS + 1);
  localparam int GAP_W  = idx_width(GAP_CYCLES);

  localparam logic [SEEK_W-1:0] IDX_END  = SEEK_W'(N_LAYERS);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LIM   = WD_W'(TIMEOUT - 1);

  sched_state_e        state_q, state_d;
  logic [SEEK_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [N_LAYERS-1:0] en_q, en_d;
  logic [N_LAYERS-1:0] skip_q, skip_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    idx_lo;
  logic                mux_idle;

  assign idx_lo = idx_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    en_d    = en_q;
    skip_d  = skip_q;
    cur_d   = cur_q;
    err_d   = err_q;
    if (abort) begin
      state_d = S_IDLE;
      en_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            skip_d  = skip_mask;
            idx_d   = '0;
            state_d = S_SEEK;
          end
        end
        S_SEEK: begin
          if (idx_q >= IDX_END) begin
            state_d = S_DONE;
          end else if (skip_q[idx_lo]) begin
            idx_d = idx_q + 1'b1;
          end else begin
            en_d         = '0;
            en_d[idx_lo] = 1'b1;
            wd_d         = '0;
            cur_d        = idx_lo;
            state_d      = S_RUN;
          end
        end
        S_RUN: begin
          // Finish beats a timeout landing on the same cycle.
          if (bus.layer_finish[idx_lo]) begin
            en_d    = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end else if ((TIMEOUT != 0) && (wd_q == WD_LIM)) begin
            en_d    = '0;
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            wd_d = wd_q + WD_W'(wd_q != '1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEEK;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
        S_ERR:  state_d = S_ERR;
        default: begin
          state_d = S_IDLE;
          en_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      en_q    <= '0;
      skip_q  <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      skip_q  <= skip_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

  assign bus.layer_en = en_q;
  assign cur_layer    = cur_q;
  assign error        = err_q;
  assign busy         = (state_q == S_RUN) || (state_q == S_GAP);
  assign done         = (state_q == S_DONE);
  assign mux_idle     = (state_q != S_RUN);

  // Pass-through only while RUN so each engine keeps its own BRAM timing.
  bram_port_mux #(
    .N      (N_LAYERS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bram_mux (
    .force_idle (mux_idle),
    .sel        (idx_lo),
    .in_ena     (bus.lyr_ena),
    .in_wea     (bus.lyr_wea),
    .in_addra   (bus.lyr_addra),
    .in_dina    (bus.lyr_dina),
    .out_ena    (bus.bram_ena),
    .out_wea    (bus.bram_wea),
    .out_addra  (bus.bram_addra),
    .out_dina   (bus.bram_dina)
  );

endmodule
